pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed ID/EX latch. It carries an arbitrary control bundle plus data payload between two CPU stages with a valid/ready handshake, stall (back-pressure), and flush (bubble insertion). An optional skid entry gives full throughput with a registered `in_ready`. One instance is used per boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/cpu_pipe_pkg.sv | 38 +++
 rtl/pipe_entry.sv | 63 ++++++
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
//
// Shared definitions for the CPU pipeline boundary registers.
//   - Field widths of the ID/EX control bundle (WB, Mem, EX groups) and the
//     resulting ID/EX control and data widths used as pipe_stage_reg defaults.
//   - idex_ctrl_t: packed view of the ID/EX control bundle, MSB group first.
//   - count_entries(): occupancy of a two-entry stage from its valid bits.
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

    // Control bundle groups carried across ID/EX.
    localparam int WB_W  = 2;   // RegWrite, MemToReg
    localparam int MEM_W = 2;   // MemRead, MemWrite
    localparam int EX_W  = 7;   // ALUSrc, ALUOp, etc.

    localparam int IDEX_CTRL_W = WB_W + MEM_W + EX_W;

    // Payload: PC (32) + Imm (32) + rs1 data (32) + rs2 data (32)
    //          + rd/rs1/rs2 addresses and spare tag bits (47).
    localparam int IDEX_DATA_W = 175;

    // Width of the occupancy count (0..2).
    localparam int OCC_W = 2;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } idex_ctrl_t;

    // Number of valid entries held by a main + skid pair.
    function automatic logic [OCC_W-1:0] count_entries(input logic main_v,
                                                       input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage : cpu_pipe_pkg

// File: rtl/pipe_entry.sv
// -----------------------------------------------------------------------------
// pipe_entry
//
// One storage slot of a pipeline stage: valid bit, control bundle and payload.
//
// Ports:
//   clk      in   clock, rising edge
//   Reset    in   synchronous active-low reset; clears valid, ctrl and data
//   load     in   capture in_ctrl/in_data and mark the entry valid
//   clear    in   invalidate the entry and zero its ctrl (wins over load)
//   in_ctrl  in   control bundle to capture
//   in_data  in   payload to capture
//   valid    out  entry holds a bundle
//   ctrl     out  stored control, forced to 0 while the entry is invalid
//   data     out  stored payload (may be stale while invalid)
// -----------------------------------------------------------------------------
module pipe_entry #(
    parameter int CTRL_W = 11,
    parameter int DATA_W = 175
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            // NOTE: the payload register is reset too, because downstream
            // expects out_data = 0 straight after reset, not just a bubble.
            data_q  <= '0;
        end else if (clear) begin
            // The payload is left as-is on clear; only valid/ctrl matter
            // for a bubble.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            ctrl_q  <= in_ctrl;
            data_q  <= in_data;
        end
    end

    // An invalid slot must never leak RegWrite/MemWrite downstream, even if
    // the ctrl register were somehow left non-zero.
    assign valid = valid_q;
    assign ctrl  = valid_q ? ctrl_q : '0;
    assign data  = data_q;

endmodule : pipe_entry

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline boundary register with valid/ready handshake,
// back-pressure (stall) and flush (bubble insertion). With SKID = 1 a second
// entry absorbs the bundle that arrives while the main entry is stalled, so
// in_ready can come straight from a flop and throughput stays at one bundle
// per cycle. With SKID = 0 a single entry is used and in_ready is
// combinational from out_ready.
//
// Ports:
//   clk        in   clock, rising edge
//   Reset      in   synchronous active-low reset
//   in_valid   in   upstream offers a bundle
//   in_ready   out  stage accepts this cycle
//   in_ctrl    in   upstream control bundle
//   in_data    in   upstream payload
//   flush      in   drop every held and incoming bundle this cycle
//   out_valid  out  out_ctrl/out_data carry a bundle
//   out_ready  in   downstream accepts; low = stall
//   out_ctrl   out  control to downstream, 0 while out_valid = 0
//   out_data   out  payload to downstream
//   occupancy  out  number of valid entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    // Main entry (drives the outputs).
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic [CTRL_W-1:0] main_load_ctrl;
    logic [DATA_W-1:0] main_load_data;

    // Skid entry (only populated when SKID = 1).
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_clear;

    logic accept;
    logic consume;

    // A bundle offered during a flush is dropped even when in_ready is high.
    assign accept  = in_valid & in_ready & ~flush;
    assign consume = main_valid & out_ready;

    // -------------------------------------------------------------------------
    // Entry control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the branches below can infer a latch.
        main_load      = 1'b0;
        main_clear     = flush;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = flush;

        if (!flush) begin
            if (!main_valid || consume) begin
                // Main is free at this edge: refill from skid first (keeps
                // order), otherwise from upstream, otherwise go empty.
                if (skid_valid) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                end else if (accept) begin
                    main_load = 1'b1;
                end else begin
                    main_clear = 1'b1;
                end
            end else if (accept) begin
                // Main is stalled: the new bundle parks in the skid entry.
                // Only reachable with SKID = 1; with SKID = 0 in_ready is low.
                skid_load = 1'b1;
            end
        end
    end

    assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_load_data = main_from_skid ? skid_data : in_data;

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .Reset   (Reset),
        .load    (main_load),
        .clear   (main_clear),
        .in_ctrl (main_load_ctrl),
        .in_data (main_load_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    // -------------------------------------------------------------------------
    // Skid entry and ready generation
    // -------------------------------------------------------------------------
    generate
        if (SKID) begin : g_skid
            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .Reset   (Reset),
                .load    (skid_load),
                .clear   (skid_clear),
                .in_ctrl (in_ctrl),
                .in_data (in_data),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );

            // Straight from a flop: no combinational path from out_ready.
            assign in_ready = ~skid_valid;
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;

            // Single entry: accept when empty or when the current bundle
            // leaves this cycle.
            assign in_ready = ~main_valid | out_ready;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = count_entries(main_valid, skid_valid);

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances share clock and reset: dut1 (SKID = 1, default widths) and
// dut0 (SKID = 0, 32-bit payload). Directed table rows cover reset,
// streaming, stall, flush and reset-mid-stall on dut1; a short hand sequence
// covers the combinational ready of dut0; a randomized phase compares both
// against a depth-limited FIFO model.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int CW  = 11;
    localparam int DW1 = 175;
    localparam int DW0 = 32;

    logic clk;
    logic Reset;

    // dut1 signals
    logic           iv1, irdy1, fl1, ov1, ordy1;
    logic [CW-1:0]  ictrl1, octrl1;
    logic [DW1-1:0] idata1, odata1;
    logic [1:0]     occ1;

    // dut0 signals
    logic           iv0, irdy0, fl0, ov0, ordy0;
    logic [CW-1:0]  ictrl0, octrl0;
    logic [DW0-1:0] idata0, odata0;
    logic [1:0]     occ0;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW1), .SKID(1'b1)) dut1 (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (iv1),
        .in_ready  (irdy1),
        .in_ctrl   (ictrl1),
        .in_data   (idata1),
        .flush     (fl1),
        .out_valid (ov1),
        .out_ready (ordy1),
        .out_ctrl  (octrl1),
        .out_data  (odata1),
        .occupancy (occ1)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW0), .SKID(1'b0)) dut0 (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (iv0),
        .in_ready  (irdy0),
        .in_ctrl   (ictrl0),
        .in_data   (idata0),
        .flush     (fl0),
        .out_valid (ov0),
        .out_ready (ordy0),
        .out_ctrl  (octrl0),
        .out_data  (odata0),
        .occupancy (occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Recognisable payload derived from the ctrl tag.
    function automatic logic [DW1-1:0] data_of(input logic [CW-1:0] c);
        logic [DW1-1:0] d;
        d          = '0;
        d[10:0]    = c;
        d[100:90]  = c ^ 11'h5A5;
        d[174:164] = ~c;
        return d;
    endfunction

    function automatic logic [DW1-1:0] rand_data();
        logic [191:0] w;
        w = '0;
        for (int i = 0; i < 6; i++) w = (w << 32) | 192'($urandom());
        return w[DW1-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Directed vectors for dut1
    // -------------------------------------------------------------------------
    typedef struct {
        logic           rst_n, iv;
        logic [CW-1:0]  ctrl;
        logic           fl, ordy;
        logic           chk;
        logic           ov;
        logic [CW-1:0]  octrl;
        logic [1:0]     occ;
        logic           irdy;
        logic           chk_data;
        logic [DW1-1:0] odata;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    // zd: also expect the payload register to be zero (after reset).
    function automatic vec_t mk(input logic rst_n, input logic iv,
                                input logic [CW-1:0] ctrl, input logic fl,
                                input logic ordy, input logic ov,
                                input logic [CW-1:0] octrl, input logic [1:0] occ,
                                input logic irdy, input logic zd);
        vec_t v;
        v.rst_n    = rst_n;
        v.iv       = iv;
        v.ctrl     = ctrl;
        v.fl       = fl;
        v.ordy     = ordy;
        v.chk      = 1'b1;
        v.ov       = ov;
        v.octrl    = octrl;
        v.occ      = occ;
        v.irdy     = irdy;
        v.chk_data = ov | zd;
        v.odata    = ov ? data_of(octrl) : '0;
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: an in-order queue of at most 1 (SKID=0) or 2 (SKID=1)
    // bundles. Index 1 = dut1, index 0 = dut0.
    // -------------------------------------------------------------------------
    logic [CW-1:0]  m_ctrl[2][2];
    logic [DW1-1:0] m_data[2][2];
    int             m_cnt[2];

    function automatic logic model_in_ready(input int k, input logic ordy);
        if (k == 1) return m_cnt[1] < 2;
        return (m_cnt[0] == 0) || ordy;
    endfunction

    task automatic model_update(input int k, input logic rst_n, input logic iv,
                                input logic [CW-1:0] ctrl,
                                input logic [DW1-1:0] data,
                                input logic fl, input logic ordy);
        logic rdy;
        rdy = model_in_ready(k, ordy);
        if (!rst_n || fl) begin
            m_cnt[k] = 0;
        end else begin
            if (m_cnt[k] > 0 && ordy) begin
                m_ctrl[k][0] = m_ctrl[k][1];
                m_data[k][0] = m_data[k][1];
                m_cnt[k]--;
            end
            if (iv && rdy) begin
                m_ctrl[k][m_cnt[k]] = ctrl;
                m_data[k][m_cnt[k]] = data;
                m_cnt[k]++;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic a_ov,
                             input logic [CW-1:0] a_ctrl,
                             input logic [DW1-1:0] a_data,
                             input logic [1:0] a_occ, input logic a_irdy,
                             input logic ordy);
        logic e_ov;
        e_ov = m_cnt[k] > 0;
        check($sformatf("rnd%0d.out_valid", k), 256'(a_ov), 256'(e_ov));
        check($sformatf("rnd%0d.out_ctrl", k), 256'(a_ctrl),
              256'(e_ov ? m_ctrl[k][0] : 11'h000));
        if (e_ov)
            check($sformatf("rnd%0d.out_data", k), 256'(a_data),
                  256'(m_data[k][0]));
        check($sformatf("rnd%0d.occupancy", k), 256'(a_occ), 256'(m_cnt[k]));
        check($sformatf("rnd%0d.in_ready", k), 256'(a_irdy),
              256'(model_in_ready(k, ordy)));
    endtask

    // One cycle of the SKID = 0 hand sequence; dut0 checks are taken with
    // the inputs already applied, so the combinational in_ready is seen.
    task automatic dut0_cycle(input int n, input logic iv, input logic [CW-1:0] c,
                              input logic ordy, input logic e_ov,
                              input logic [CW-1:0] e_ctrl, input logic e_irdy,
                              input logic [1:0] e_occ);
        @(negedge clk);
        iv0    = iv;
        ictrl0 = c;
        idata0 = data_of(c)[DW0-1:0];
        ordy0  = ordy;
        #1;
        check($sformatf("s0[%0d].out_valid", n), 256'(ov0), 256'(e_ov));
        check($sformatf("s0[%0d].out_ctrl", n), 256'(octrl0), 256'(e_ctrl));
        check($sformatf("s0[%0d].in_ready", n), 256'(irdy0), 256'(e_irdy));
        check($sformatf("s0[%0d].occupancy", n), 256'(occ0), 256'(e_occ));
        if (e_ov)
            check($sformatf("s0[%0d].out_data", n), 256'(odata0),
                  256'(data_of(e_ctrl)[DW0-1:0]));
    endtask

    initial begin
        Reset  = 1'b0;
        iv1 = 1'b0; ictrl1 = '0; idata1 = '0; fl1 = 1'b0; ordy1 = 1'b1;
        iv0 = 1'b0; ictrl0 = '0; idata0 = '0; fl0 = 1'b0; ordy0 = 1'b1;

        //               rst iv ctrl    fl ordy  ov octrl   occ rdy zd
        vecs[0]  = mk(0, 1, 11'h123, 0, 1,   0, 11'h000, 0, 1, 0);
        vecs[0].chk = 1'b0;   // state before the first edge is undefined
        vecs[1]  = mk(0, 1, 11'h123, 0, 1,   0, 11'h000, 0, 1, 1);
        vecs[2]  = mk(1, 1, 11'h7FF, 0, 1,   0, 11'h000, 0, 1, 1);
        vecs[3]  = mk(1, 1, 11'h001, 0, 1,   1, 11'h7FF, 1, 1, 0);
        vecs[4]  = mk(1, 1, 11'h155, 0, 1,   1, 11'h001, 1, 1, 0);
        vecs[5]  = mk(1, 0, 11'h000, 0, 1,   1, 11'h155, 1, 1, 0);
        vecs[6]  = mk(1, 0, 11'h000, 0, 1,   0, 11'h000, 0, 1, 0);
        // stall: two accepted, third held upstream
        vecs[7]  = mk(1, 1, 11'h0A1, 0, 0,   0, 11'h000, 0, 1, 0);
        vecs[8]  = mk(1, 1, 11'h0A2, 0, 0,   1, 11'h0A1, 1, 1, 0);
        vecs[9]  = mk(1, 1, 11'h0A3, 0, 0,   1, 11'h0A1, 2, 0, 0);
        vecs[10] = mk(1, 1, 11'h0A3, 0, 0,   1, 11'h0A1, 2, 0, 0);
        vecs[11] = mk(1, 1, 11'h0A3, 0, 1,   1, 11'h0A1, 2, 0, 0);
        vecs[12] = mk(1, 1, 11'h0A3, 0, 1,   1, 11'h0A2, 1, 1, 0);
        vecs[13] = mk(1, 0, 11'h000, 0, 1,   1, 11'h0A3, 1, 1, 0);
        vecs[14] = mk(1, 0, 11'h000, 0, 1,   0, 11'h000, 0, 1, 0);
        // flush from full, then flush dropping a bundle offered with ready=1
        vecs[15] = mk(1, 1, 11'h0B1, 0, 0,   0, 11'h000, 0, 1, 0);
        vecs[16] = mk(1, 1, 11'h0B2, 0, 0,   1, 11'h0B1, 1, 1, 0);
        vecs[17] = mk(1, 1, 11'h0B3, 1, 0,   1, 11'h0B1, 2, 0, 0);
        vecs[18] = mk(1, 1, 11'h0B4, 1, 1,   0, 11'h000, 0, 1, 0);
        vecs[19] = mk(1, 0, 11'h000, 0, 1,   0, 11'h000, 0, 1, 0);
        // flush while the current bundle is consumed: nothing follows
        vecs[20] = mk(1, 1, 11'h0C1, 0, 1,   0, 11'h000, 0, 1, 0);
        vecs[21] = mk(1, 0, 11'h000, 1, 1,   1, 11'h0C1, 1, 1, 0);
        vecs[22] = mk(1, 0, 11'h000, 0, 1,   0, 11'h000, 0, 1, 0);
        // reset (with flush) mid-stall at occupancy 2
        vecs[23] = mk(1, 1, 11'h0D1, 0, 0,   0, 11'h000, 0, 1, 0);
        vecs[24] = mk(1, 1, 11'h0D2, 0, 0,   1, 11'h0D1, 1, 1, 0);
        vecs[25] = mk(1, 1, 11'h0D3, 0, 0,   1, 11'h0D1, 2, 0, 0);
        vecs[26] = mk(0, 1, 11'h0D3, 1, 0,   1, 11'h0D1, 2, 0, 0);
        vecs[27] = mk(1, 0, 11'h000, 0, 1,   0, 11'h000, 0, 1, 1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            Reset  = vecs[i].rst_n;
            iv1    = vecs[i].iv;
            ictrl1 = vecs[i].ctrl;
            idata1 = data_of(vecs[i].ctrl);
            fl1    = vecs[i].fl;
            ordy1  = vecs[i].ordy;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v[%0d].out_valid", i), 256'(ov1), 256'(vecs[i].ov));
                check($sformatf("v[%0d].out_ctrl", i), 256'(octrl1), 256'(vecs[i].octrl));
                check($sformatf("v[%0d].occupancy", i), 256'(occ1), 256'(vecs[i].occ));
                check($sformatf("v[%0d].in_ready", i), 256'(irdy1), 256'(vecs[i].irdy));
                if (vecs[i].chk_data)
                    check($sformatf("v[%0d].out_data", i), 256'(odata1),
                          256'(vecs[i].odata));
            end
        end

        // Park dut1 idle; SKID = 0 sequence on dut0 (empty since reset).
        @(negedge clk);
        iv1 = 1'b0; fl1 = 1'b0; ordy1 = 1'b1;
        //         n  iv ctrl     ordy  ov ctrl     rdy occ
        dut0_cycle(0, 1, 11'h0E1, 1,    0, 11'h000, 1, 0);
        dut0_cycle(1, 1, 11'h0E2, 0,    1, 11'h0E1, 0, 1);
        dut0_cycle(2, 1, 11'h0E2, 1,    1, 11'h0E1, 1, 1);
        dut0_cycle(3, 0, 11'h000, 0,    1, 11'h0E2, 0, 1);
        dut0_cycle(4, 0, 11'h000, 1,    1, 11'h0E2, 1, 1);
        dut0_cycle(5, 0, 11'h000, 1,    0, 11'h000, 1, 0);

        // Randomized phase against the queue model; both DUTs are empty here.
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        for (int c = 0; c < 600; c++) begin
            logic [DW1-1:0] d0;
            @(negedge clk);
            Reset  = ($urandom_range(63) != 0);
            iv1    = ($urandom_range(3) != 0);
            ictrl1 = CW'($urandom());
            idata1 = rand_data();
            fl1    = ($urandom_range(15) == 0);
            ordy1  = ($urandom_range(9) < 5);
            iv0    = ($urandom_range(3) != 0);
            ictrl0 = CW'($urandom());
            idata0 = $urandom();
            fl0    = ($urandom_range(15) == 0);
            ordy0  = ($urandom_range(9) < 6);
            d0     = DW1'(idata0);
            #1;
            check_dut(1, ov1, octrl1, odata1, occ1, irdy1, ordy1);
            check_dut(0, ov0, octrl0, DW1'(odata0), occ0, irdy0, ordy0);
            @(posedge clk);
            model_update(1, Reset, iv1, ictrl1, idata1, fl1, ordy1);
            model_update(0, Reset, iv0, ictrl0, d0, fl0, ordy0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_stage_reg
